// File: rtl/alu_seq_core.sv
// alu_seq_core: WIDTH-bit sequential ALU fed by a shared opcode/A/B beat
// stream over valid/ready, returning one result beat (two for multiply)
// with status flags {err, ovf, neg, zero, carry}.
// Optional multiplier: define ALU_MUL_EN to build the shift-add MUL path;
// otherwise opcode 8 is reported as illegal.
module alu_seq_core #(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_flags,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);

  // MUL_CYCLES is informational only; it must track WIDTH.
  if (WIDTH < 4 || MUL_CYCLES != WIDTH) begin : g_bad_cfg
    $error("alu_seq_core: WIDTH must be >= 4 and MUL_CYCLES must equal WIDTH");
  end

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_MUL = 4'd8
  } opcode_t;

  typedef enum logic [2:0] {
    GET_OP,
    GET_A,
    GET_B,
    EXEC,
`ifdef ALU_MUL_EN
    MUL,
    OUT_HI,
`endif
    OUT_LO
  } state_t;

  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  state_t           state;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_data;
  logic [4:0]       res_flags;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_dif;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic             big_shift;
  logic [WIDTH-1:0] exec_res;
  logic             exec_carry;
  logic             exec_ovf;
  logic             exec_err;
  logic [4:0]       exec_flags;

  // Single-cycle ALU result and flags from the captured operands
  always_comb begin
    add_sum   = {1'b0, a_reg} + {1'b0, b_reg};
    sub_dif   = {1'b0, a_reg} - {1'b0, b_reg};
    // One extra bit on each side keeps the last bit shifted out visible.
    shl_ext   = {1'b0, a_reg} << b_reg;
    shr_ext   = {a_reg, 1'b0} >> b_reg;
    big_shift = (b_reg >= W_VAL);
    exec_res   = '0;
    exec_carry = 1'b0;
    exec_ovf   = 1'b0;
    exec_err   = 1'b0;
    case (op_reg)
      OP_ADD: begin
        exec_res   = add_sum[WIDTH-1:0];
        exec_carry = add_sum[WIDTH];
        exec_ovf   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                     (add_sum[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_SUB: begin
        exec_res   = sub_dif[WIDTH-1:0];
        exec_carry = sub_dif[WIDTH];
        exec_ovf   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                     (sub_dif[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_AND: exec_res = a_reg & b_reg;
      OP_OR:  exec_res = a_reg | b_reg;
      OP_XOR: exec_res = a_reg ^ b_reg;
      OP_NOT: exec_res = ~a_reg;
      OP_SHL: begin
        exec_res   = big_shift ? '0 : shl_ext[WIDTH-1:0];
        exec_carry = shl_ext[WIDTH];
      end
      OP_SHR: begin
        exec_res   = big_shift ? '0 : shr_ext[WIDTH:1];
        exec_carry = shr_ext[0];
      end
      default: exec_err = 1'b1;
    endcase
    exec_flags = exec_err ? 5'b10000
                          : {1'b0, exec_ovf, exec_res[WIDTH-1], (exec_res == '0), exec_carry};
  end

`ifdef ALU_MUL_EN
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     mul_sum;
  logic [CNT_W-1:0]   mul_cnt;
  logic               is_mul;

  assign is_mul = (op_reg == OP_MUL);

  // One shift-add step: multiplier sits in the low half and shifts out
  // while the partial product accumulates into the high half.
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_reg} : '0);
    prod_next = {mul_sum, prod[WIDTH-1:1]};
  end
`endif

  // Control FSM with registered handshake and output beat registers
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state     <= GET_OP;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
      out_last  <= 1'b0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_data  <= '0;
      res_flags <= '0;
`ifdef ALU_MUL_EN
      prod      <= '0;
      mul_cnt   <= '0;
`endif
    end else begin
      case (state)
        GET_OP: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            op_reg <= in_data[3:0];
            state  <= GET_A;
          end
        end
        GET_A: begin
          if (in_valid && in_ready) begin
            a_reg <= in_data;
            state <= GET_B;
          end
        end
        GET_B: begin
          if (in_valid && in_ready) begin
            b_reg    <= in_data;
            in_ready <= 1'b0;
`ifdef ALU_MUL_EN
            if (is_mul) begin
              prod    <= {{WIDTH{1'b0}}, in_data};
              mul_cnt <= '0;
              state   <= MUL;
            end else begin
              state <= EXEC;
            end
`else
            state <= EXEC;
`endif
          end
        end
        EXEC: begin
          res_data  <= exec_res;
          res_flags <= exec_flags;
          state     <= OUT_LO;
        end
`ifdef ALU_MUL_EN
        MUL: begin
          prod    <= prod_next;
          mul_cnt <= mul_cnt + 1'b1;
          if (mul_cnt == MUL_LAST) begin
            res_data  <= prod_next[WIDTH-1:0];
            res_flags <= {2'b00, prod_next[2*WIDTH-1], (prod_next == '0), 1'b0};
            state     <= OUT_LO;
          end
        end
`endif
        OUT_LO: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= res_data;
            out_flags <= res_flags;
`ifdef ALU_MUL_EN
            out_last  <= !is_mul;
`else
            out_last  <= 1'b1;
`endif
          end else if (out_ready) begin
`ifdef ALU_MUL_EN
            if (is_mul) begin
              out_data <= prod[2*WIDTH-1:WIDTH];
              out_last <= 1'b1;
              state    <= OUT_HI;
            end else begin
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              state     <= GET_OP;
            end
`else
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= GET_OP;
`endif
          end
        end
`ifdef ALU_MUL_EN
        OUT_HI: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= GET_OP;
          end
        end
`endif
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          state     <= GET_OP;
        end
      endcase
    end
  end

endmodule
